// File: rtl/sblk_pkg.sv
// Shared types and depth helpers for the superblock row skew network.
package sblk_pkg;

    typedef enum logic {SKEW_SYSTOLIC = 1'b0, SKEW_BCAST = 1'b1} skew_mode_e;

    // Forward depth of column col in systolic mode: one launch register plus per-hop skew.
    function automatic int unsigned fwd_depth(input int unsigned col, input int unsigned skew);
        return 32'd1 + col * skew;
    endfunction

    // Return depth of column col in systolic mode: the last column needs no de-skew.
    function automatic int unsigned ret_depth(input int unsigned col, input int unsigned n_col,
                                              input int unsigned skew);
        return (n_col - 32'd1 - col) * skew;
    endfunction

endpackage

// File: rtl/skew_dly_line.sv
// Valid+data shift register with synchronous valid flush; DEPTH=0 is a pass-through.
module skew_dly_line
    import sblk_pkg::*;
#(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_l,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             first_vld,
    output logic [WIDTH-1:0] first_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    output logic             any_vld
);

    if (DEPTH == 0) begin : g_pass
        assign first_vld  = in_vld;
        assign first_data = in_data;
        assign out_vld    = in_vld;
        assign out_data   = in_data;
        assign any_vld    = 1'b0;
    end else begin : g_pipe
        logic [DEPTH-1:0]            vld_q;
        logic [DEPTH-1:0][WIDTH-1:0] data_q;

        // Shift valid and data one stage per cycle; flush kills valids only.
        always_ff @(posedge clk_l or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= '0;
                data_q <= '0;
            end else begin
                vld_q[0]  <= in_vld & ~flush;
                data_q[0] <= in_data;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    vld_q[i]  <= vld_q[i-1] & ~flush;
                    data_q[i] <= data_q[i-1];
                end
            end
        end

        assign first_vld  = vld_q[0];
        assign first_data = data_q[0];
        assign out_vld    = vld_q[DEPTH-1];
        assign out_data   = data_q[DEPTH-1];
        assign any_vld    = |vld_q;
    end

endmodule

// File: rtl/sblk_skew_net.sv
// Row skew network: systolic/broadcast forward distribution and return de-skew.
module sblk_skew_net
    import sblk_pkg::*;
#(
    parameter int unsigned N_COLUMN = 4,
    parameter int unsigned SKEW     = 1,
    parameter int unsigned WID_BUS  = 64,
    parameter int unsigned WID_RET  = 64
) (
    input  logic                         clk_l,
    input  logic                         rst_n,
    input  logic                         mode_bcast,
    input  logic [N_COLUMN-1:0]          col_en,
    input  logic                         flush,
    input  logic                         err_clr,
    input  logic [WID_BUS-1:0]           bus_in,
    input  logic                         bus_in_vld,
    output logic [N_COLUMN*WID_BUS-1:0]  bus_out,
    output logic [N_COLUMN-1:0]          bus_out_vld,
    input  logic [N_COLUMN*WID_RET-1:0]  ret_in,
    input  logic [N_COLUMN-1:0]          ret_in_vld,
    output logic [N_COLUMN*WID_RET-1:0]  ret_out,
    output logic                         ret_out_vld,
    output logic                         busy,
    output logic                         err_align
);

    skew_mode_e                  mode_q;
    logic [N_COLUMN-1:0]         en_q;
    logic [N_COLUMN-1:0]         fwd_busy;
    logic [N_COLUMN-1:0]         ret_busy;
    logic [N_COLUMN-1:0]         al_vld;
    logic [N_COLUMN*WID_RET-1:0] al_data;
    logic [N_COLUMN-1:0]         al_hit;
    logic [N_COLUMN*WID_RET-1:0] ret_masked;
    logic                        beat_ok;
    logic                        beat_bad;

    assign busy = (|fwd_busy) | (|ret_busy) | ret_out_vld;

    // Config only changes with nothing in flight, so a beat never sees a mixed geometry.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= SKEW_SYSTOLIC;
            en_q   <= '1;
        end else if (!busy && !bus_in_vld) begin
            mode_q <= skew_mode_e'(mode_bcast);
            en_q   <= col_en;
        end
    end

    for (genvar c = 0; c < int'(N_COLUMN); c++) begin : g_col
        localparam int unsigned FwdDepth = fwd_depth(c, SKEW);
        localparam int unsigned RetDepth = ret_depth(c, N_COLUMN, SKEW);

        logic               f_first_vld, f_out_vld;
        logic [WID_BUS-1:0] f_first_data, f_out_data;
        logic               r_first_vld, r_out_vld, r_in_vld;
        logic [WID_RET-1:0] r_first_data, r_out_data;

        skew_dly_line #(
            .DEPTH(FwdDepth),
            .WIDTH(WID_BUS)
        ) u_fwd (
            .clk_l     (clk_l),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_vld    (bus_in_vld),
            .in_data   (bus_in),
            .first_vld (f_first_vld),
            .first_data(f_first_data),
            .out_vld   (f_out_vld),
            .out_data  (f_out_data),
            .any_vld   (fwd_busy[c])
        );

        // Broadcast takes the first tap so every column sees the beat one cycle later.
        assign bus_out_vld[c] = ((mode_q == SKEW_BCAST) ? f_first_vld : f_out_vld) & en_q[c];
        assign bus_out[c*WID_BUS +: WID_BUS] = (mode_q == SKEW_BCAST) ? f_first_data
                                                                       : f_out_data;

        // Disabled columns and broadcast returns never enter the de-skew line.
        assign r_in_vld = ret_in_vld[c] & en_q[c] & (mode_q == SKEW_SYSTOLIC);

        skew_dly_line #(
            .DEPTH(RetDepth),
            .WIDTH(WID_RET)
        ) u_ret (
            .clk_l     (clk_l),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_vld    (r_in_vld),
            .in_data   (ret_in[c*WID_RET +: WID_RET]),
            .first_vld (r_first_vld),
            .first_data(r_first_data),
            .out_vld   (r_out_vld),
            .out_data  (r_out_data),
            .any_vld   (ret_busy[c])
        );

        assign al_vld[c] = (mode_q == SKEW_BCAST) ? ret_in_vld[c] : r_out_vld;
        assign al_data[c*WID_RET +: WID_RET] = (mode_q == SKEW_BCAST)
                                               ? ret_in[c*WID_RET +: WID_RET] : r_out_data;
    end

    // Aligned-stage decision: complete beat, partial (misaligned) beat, or nothing.
    always_comb begin
        al_hit     = al_vld & en_q;
        beat_ok    = !flush && (al_hit == en_q) && (en_q != '0);
        beat_bad   = !flush && (al_hit != '0) && (al_hit != en_q);
        ret_masked = '0;
        for (int c = 0; c < int'(N_COLUMN); c++) begin
            if (en_q[c]) begin
                ret_masked[c*WID_RET +: WID_RET] = al_data[c*WID_RET +: WID_RET];
            end
        end
    end

    // Common output register; data only loads with a complete beat.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            ret_out_vld <= 1'b0;
            ret_out     <= '0;
        end else begin
            ret_out_vld <= beat_ok;
            if (beat_ok) begin
                ret_out <= ret_masked;
            end
        end
    end

    // Sticky misalignment flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            err_align <= 1'b0;
        end else if (beat_bad) begin
            err_align <= 1'b1;
        end else if (err_clr) begin
            err_align <= 1'b0;
        end
    end

endmodule

// File: doc/sblk_skew_net.md
# sblk_skew_net

Parametrised control/data skew network for a superblock row. It distributes one issue-side bus beat to `N_COLUMN` sblk_unit columns, either as a systolic wavefront (configurable per-hop skew) or as a same-cycle broadcast. It also de-skews the per-column psum returns into a single aligned output beat. It sits between sblk_ctrl and the column array and replaces the fixed one-cycle-per-column delay registers in the row wrapper.

## Interface
- `N_COLUMN`, 4, number of columns (≥1)
- `SKEW`, 1, cycles of delay per column hop in systolic mode (≥1)
- `WID_BUS`, 64, packed forward beat width (act data + act/w/psum addresses + enables)
- `WID_RET`, 64, per-column return width (2×WID_PSUM)

- `clk_l`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `mode_bcast`  in  1  requested mode: 0 systolic, 1 broadcast
- `col_en`  in  N_COLUMN  requested column enable mask
- `flush`  in  1  synchronous kill of all in-flight valids
- `err_clr`  in  1  clears `err_align`
- `bus_in`  in  WID_BUS  forward beat
- `bus_in_vld`  in  1  forward beat valid
- `bus_out`  out  N_COLUMN×WID_BUS  per-column beat; column c at `[c*WID_BUS +: WID_BUS]`
- `bus_out_vld`  out  N_COLUMN  per-column valid
- `ret_in`  in  N_COLUMN×WID_RET  per-column return data
- `ret_in_vld`  in  N_COLUMN  per-column return valid
- `ret_out`  out  N_COLUMN×WID_RET  aligned return beat
- `ret_out_vld`  out  1  aligned return valid
- `busy`  out  1  any forward or return valid in flight
- `err_align`  out  1  sticky misalignment flag

## Operation
- **Config latch.** `mode_q`/`en_q` load from `mode_bcast`/`col_en` only in a cycle where `busy==0` and `bus_in_vld==0`. Otherwise they hold; a change requested while busy is deferred until idle. Reset values: `mode_q=0`, `en_q` all ones.
- **Forward path.** Column c delay is 1+c·SKEW in systolic mode and 1 in broadcast mode.
  - `bus_out_vld[c]` = delayed valid AND `en_q[c]`.
  - `bus_out` data is delayed the same amount; data is not gated.
- **Return path.** Column c return is delayed (N_COLUMN−1−c)·SKEW in systolic mode and 0 in broadcast mode, then passes through one common output register.
  - At the aligned stage, let A = aligned valids AND `en_q`.
  - If A == `en_q` and `en_q`≠0, then `ret_out_vld`=1 next cycle.
  - If A is nonzero but not equal to `en_q`, the beat is dropped (`ret_out_vld`=0) and `err_align` is set.
  - `ret_out` slices of disabled columns read 0.
  - `ret_in_vld` of disabled columns is ignored.
- **Flush.** The cycle after `flush`, all forward and return valid bits are 0.
  - Data registers are not cleared.
  - `flush` wins over a simultaneous `bus_in_vld` or `ret_in_vld`; that beat is dropped.
  - Flush does not clear `err_align`.
- **Error flag.** `err_align` is cleared only by `err_clr` or reset. If a set condition and `err_clr` occur in the same cycle, set wins.
- **Busy.** `busy` is the OR of every valid register in both paths and the output register.
- **Reset.** All valids, data registers, `ret_out`, `err_align` and `busy` are 0. Reset mid-flight discards everything asynchronously.

## Timing
- Forward: beat accepted at cycle t appears at column c at t+1+c·SKEW (systolic) or t+1 (broadcast). No backpressure; one beat per cycle sustained.
- Return: if column 0 returns at cycle r and column c at r+c·SKEW, `ret_out_vld` rises at r+(N_COLUMN−1)·SKEW+1 (systolic). In broadcast mode it rises at r+1.
- Back-to-back beats stay distinct; the pipeline is fully pipelined with no bubbles.
- N_COLUMN=1 is legal: only the 1-cycle forward and output registers remain.

## Structure
- `sblk_pkg`: `typedef enum logic {SKEW_SYSTOLIC, SKEW_BCAST} skew_mode_e`, and a function computing the per-column forward and return depth.
- Sub-module `skew_dly_line`.
  - Parameters: `DEPTH`, `WIDTH`.
  - Valid+data shift register with `flush`.
  - `DEPTH=0` is a combinational pass-through.
- Instantiate one `skew_dly_line` per column per direction at systolic depth. Broadcast mode uses a tap mux selecting the first tap on the forward path and the direct input on the return path.

## Test plan
- **Systolic forward.** N_COLUMN=4, SKEW=2, `bus_in`=0xA5 valid at cycle 0 -> `bus_out_vld[0..3]` high at cycles 1, 3, 5, 7, each slice 0xA5.
- **Broadcast.** `mode_bcast`=1 applied while idle, beat at cycle 0 -> all four valids high at cycle 1. Toggling `mode_bcast` while `busy`=1 has no effect until idle.
- **Return de-skew.** `ret_in_vld[c]` at cycle 10+2c with data c+1 -> `ret_out_vld` at cycle 17 with slices {4,3,2,1}.
- **Column mask.** `col_en`=4'b0101 -> only columns 0 and 2 receive valids. Returns from columns 0 and 2 alone produce `ret_out_vld`; slices 1 and 3 read 0.
- **Flush.** Beat at cycle 0, `flush` at cycle 3 -> columns 2 and 3 never assert valid; `busy`=0 at cycle 4.
- **Misalignment.** Column 1 returns one cycle late -> no `ret_out_vld` for that beat and `err_align`=1. The flag stays set through a flush and clears after `err_clr`.
